// File: rtl/motion_zone_pkg.sv
// Shared types, helpers and reference VGA timing for the motion zone tracker.
package motion_zone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCAN,
    ST_DECIDE
  } zone_state_t;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  localparam int VGA800_H_START = 216;
  localparam int VGA800_V_START = 27;
  localparam int VGA800_H_ACT   = 800;
  localparam int VGA800_V_ACT   = 600;

  localparam int VGA640_H_START = 144;
  localparam int VGA640_V_START = 35;
  localparam int VGA640_H_ACT   = 640;
  localparam int VGA640_V_ACT   = 480;

endpackage

// File: rtl/zone_argmax_scan.sv
// Sequential argmax over a flattened vector of counters, one value per cycle.
module zone_argmax_scan
  import motion_zone_pkg::*;
#(
  parameter int N_VALUES = 7,
  parameter int VAL_W    = 18,
  parameter int IDX_W    = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [N_VALUES*VAL_W-1:0]   i_values,
  output logic                        o_done,
  output logic [VAL_W-1:0]            o_maxVal,
  output logic [IDX_W-1:0]            o_maxIdx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VALUES - 1);

  logic [IDX_W-1:0] r_ptr;
  logic             r_busy;
  logic [VAL_W-1:0] w_cur;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < N_VALUES; i++) begin
      if (r_ptr == IDX_W'(i)) begin
        w_cur = i_values[i*VAL_W +: VAL_W];
      end
    end
  end

  // Start loads entry 0; strict greater-than keeps the lowest index on ties.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr    <= '0;
      r_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_maxVal <= '0;
      o_maxIdx <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        o_maxVal <= i_values[VAL_W-1:0];
        o_maxIdx <= '0;
        r_ptr    <= IDX_W'(1);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (w_cur > o_maxVal) begin
          o_maxVal <= w_cur;
          o_maxIdx <= r_ptr;
        end
        if (r_ptr == LAST_IDX) begin
          r_busy <= 1'b0;
          o_done <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/motion_zone_tracker.sv
// Per-frame strip histogram of bright pixels, argmax winner and multi-frame debounce.
module motion_zone_tracker
  import motion_zone_pkg::*;
#(
  parameter int H_START      = VGA800_H_START,
  parameter int V_START      = VGA800_V_START,
  parameter int H_ACT        = VGA800_H_ACT,
  parameter int V_ACT        = VGA800_V_ACT,
  parameter int N_ZONES      = 7,
  parameter int COLOR_THRESH = 200,
  parameter int MIN_PIXELS   = 600,
  parameter int HOLD_FRAMES  = 3,
  parameter int CNT_W        = 18
) (
  input  logic                             iCLK,
  input  logic                             iRST_N,
  input  logic [12:0]                      iH_Cont,
  input  logic [12:0]                      iV_Cont,
  input  logic [9:0]                       iColorVal,
  output logic [clog2(N_ZONES+1)-1:0]      oDirection,
  output logic                             oValid,
  output logic [clog2(N_ZONES+1)-1:0]      oCandidate,
  output logic [CNT_W-1:0]                 oPeakCount
);

  localparam int ZW     = clog2(N_ZONES + 1);
  localparam int ZONE_W = H_ACT / N_ZONES;
  localparam int HOLD_W = clog2(HOLD_FRAMES + 1);

  localparam logic [ZW-1:0]     NONE      = ZW'(N_ZONES);
  localparam logic [ZW-1:0]     LAST_ZONE = ZW'(N_ZONES - 1);
  localparam logic [12:0]       COL_LAST  = 13'(ZONE_W - 1);
  localparam logic [13:0]       H_FIRST   = 14'(H_START);
  localparam logic [13:0]       H_END     = 14'(H_START + H_ACT);
  localparam logic [13:0]       H_LAST    = 14'(H_START + H_ACT - 1);
  localparam logic [13:0]       V_FIRST   = 14'(V_START);
  localparam logic [13:0]       V_END     = 14'(V_START + V_ACT);
  localparam logic [13:0]       V_LAST    = 14'(V_START + V_ACT - 1);
  localparam logic [10:0]       THRESH    = 11'(COLOR_THRESH);
  localparam logic [31:0]       MIN_P     = 32'(MIN_PIXELS);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);

  zone_state_t       r_state;
  logic [CNT_W-1:0]  r_zoneCnt [N_ZONES];
  logic [ZW-1:0]     r_zone;
  logic [12:0]       r_col;
  logic              r_scanStart;
  logic [HOLD_W-1:0] r_hold;
  logic [ZW-1:0]     r_lastCand;

  logic [13:0]              w_h;
  logic [13:0]              w_v;
  logic                     w_vInside;
  logic                     w_active;
  logic                     w_hit;
  logic                     w_frameStart;
  logic                     w_lastPixel;
  logic [ZW-1:0]            w_zone;
  logic [12:0]              w_col;
  logic [ZW-1:0]            w_zoneNext;
  logic [12:0]              w_colNext;
  logic [N_ZONES*CNT_W-1:0] w_cntFlat;
  logic                     w_scanDone;
  logic [CNT_W-1:0]         w_maxVal;
  logic [ZW-1:0]            w_maxIdx;
  logic [ZW-1:0]            w_cand;
  logic [HOLD_W-1:0]        w_holdNext;

  assign w_h          = {1'b0, iH_Cont};
  assign w_v          = {1'b0, iV_Cont};
  assign w_vInside    = (w_v >= V_FIRST) && (w_v < V_END);
  assign w_active     = w_vInside && (w_h >= H_FIRST) && (w_h < H_END);
  assign w_hit        = w_active && ({1'b0, iColorVal} > THRESH);
  assign w_frameStart = (w_h == H_FIRST) && (w_v == V_FIRST);
  assign w_lastPixel  = (w_h == H_LAST) && (w_v == V_LAST);

  // Column counter restarts at H_START; the last zone never advances so it soaks up remainder columns.
  always_comb begin
    if (w_h == H_FIRST) begin
      w_zone = '0;
      w_col  = '0;
    end else begin
      w_zone = r_zone;
      w_col  = r_col;
    end
    w_zoneNext = w_zone;
    w_colNext  = w_col;
    if (w_zone != LAST_ZONE) begin
      if (w_col == COL_LAST) begin
        w_zoneNext = w_zone + 1'b1;
        w_colNext  = '0;
      end else begin
        w_colNext = w_col + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_ZONES; g++) begin : g_flat
    assign w_cntFlat[g*CNT_W +: CNT_W] = r_zoneCnt[g];
  end

  zone_argmax_scan #(
    .N_VALUES (N_ZONES),
    .VAL_W    (CNT_W),
    .IDX_W    (ZW)
  ) u_scan (
    .i_clk    (iCLK),
    .i_rst_n  (iRST_N),
    .i_start  (r_scanStart),
    .i_values (w_cntFlat),
    .o_done   (w_scanDone),
    .o_maxVal (w_maxVal),
    .o_maxIdx (w_maxIdx)
  );

  always_comb begin
    w_cand = (32'(w_maxVal) >= MIN_P) ? w_maxIdx : NONE;
    if (w_cand == r_lastCand) begin
      w_holdNext = (r_hold >= HOLD_MAX) ? HOLD_MAX : r_hold + 1'b1;
    end else begin
      w_holdNext = HOLD_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_zone      <= '0;
      r_col       <= '0;
      r_scanStart <= 1'b0;
      r_hold      <= '0;
      r_lastCand  <= NONE;
      oDirection  <= NONE;
      oCandidate  <= NONE;
      oValid      <= 1'b0;
      oPeakCount  <= '0;
      for (int z = 0; z < N_ZONES; z++) begin
        r_zoneCnt[z] <= '0;
      end
    end else begin
      r_zone      <= w_zoneNext;
      r_col       <= w_colNext;
      r_scanStart <= 1'b0;
      oValid      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_frameStart) begin
            for (int z = 0; z < N_ZONES; z++) begin
              r_zoneCnt[z] <= (w_hit && (w_zone == ZW'(z))) ? CNT_W'(1) : '0;
            end
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          for (int z = 0; z < N_ZONES; z++) begin
            if (w_hit && (w_zone == ZW'(z)) && (r_zoneCnt[z] != '1)) begin
              r_zoneCnt[z] <= r_zoneCnt[z] + 1'b1;
            end
          end
          if (w_lastPixel) begin
            r_state     <= ST_SCAN;
            r_scanStart <= 1'b1;
          end else if (!w_vInside) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (w_scanDone) begin
            r_state <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          r_hold     <= w_holdNext;
          r_lastCand <= w_cand;
          if (w_holdNext >= HOLD_MAX) begin
            oDirection <= w_cand;
          end
          oCandidate <= w_cand;
          oPeakCount <= (w_cand == NONE) ? '0 : w_maxVal;
          oValid     <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_zone_tracker.sv
// Directed frame-level bench: small raster, three tracker configurations driven from one H/V sweep.
module tb_motion_zone_tracker;

  localparam int HS      = 4;
  localparam int VS      = 2;
  localparam int VA      = 4;
  localparam int H_TOTAL = 24;
  localparam int V_TOTAL = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic [12:0] hCont;
  logic [12:0] vCont;
  logic [9:0]  colorA;
  logic [9:0]  colorB;
  logic [9:0]  colorC;

  logic [2:0]  dirA, candA, dirB, candB, dirC, candC;
  logic        validA, validB, validC;
  logic [17:0] peakA, peakC;
  logic [2:0]  peakB;

  int checkCount = 0;
  int failCount  = 0;
  int edgeNo     = 0;
  int validCntA, validCntB, validCntC;
  int validEdgeA, validEdgeC, lastEdgeA, lastEdgeC;

  logic [31:0] maskA, maskB, maskC;
  logic [7:0]  rowsA;
  logic [9:0]  valA;

  always #5 clk = ~clk;

  motion_zone_tracker #(
    .H_START(HS), .V_START(VS), .H_ACT(16), .V_ACT(VA), .N_ZONES(4),
    .COLOR_THRESH(200), .MIN_PIXELS(3), .HOLD_FRAMES(2), .CNT_W(18)
  ) dutA (
    .iCLK(clk), .iRST_N(rstN), .iH_Cont(hCont), .iV_Cont(vCont), .iColorVal(colorA),
    .oDirection(dirA), .oValid(validA), .oCandidate(candA), .oPeakCount(peakA)
  );

  motion_zone_tracker #(
    .H_START(HS), .V_START(VS), .H_ACT(16), .V_ACT(VA), .N_ZONES(4),
    .COLOR_THRESH(200), .MIN_PIXELS(3), .HOLD_FRAMES(2), .CNT_W(3)
  ) dutB (
    .iCLK(clk), .iRST_N(rstN), .iH_Cont(hCont), .iV_Cont(vCont), .iColorVal(colorB),
    .oDirection(dirB), .oValid(validB), .oCandidate(candB), .oPeakCount(peakB)
  );

  motion_zone_tracker #(
    .H_START(HS), .V_START(VS), .H_ACT(18), .V_ACT(VA), .N_ZONES(4),
    .COLOR_THRESH(200), .MIN_PIXELS(3), .HOLD_FRAMES(2), .CNT_W(18)
  ) dutC (
    .iCLK(clk), .iRST_N(rstN), .iH_Cont(hCont), .iV_Cont(vCont), .iColorVal(colorC),
    .oDirection(dirC), .oValid(validC), .oCandidate(candC), .oPeakCount(peakC)
  );

  function automatic logic [9:0] pixelVal(input int h, input int v, input int hAct,
                                          input logic [31:0] cols, input logic [7:0] rows,
                                          input logic [9:0] val);
    if (h >= HS && h < HS + hAct && v >= VS && v < VS + VA) begin
      if (cols[h-HS] && rows[v-VS]) return val;
    end
    return 10'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One full raster; rstLine >= 0 pulses reset from that line to the next, mid-frame.
  task automatic applyStimulus(input int rstLine);
    validCntA = 0;
    validCntB = 0;
    validCntC = 0;
    for (int v = 0; v < V_TOTAL; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        hCont  = 13'(h);
        vCont  = 13'(v);
        colorA = pixelVal(h, v, 16, maskA, rowsA, valA);
        colorB = pixelVal(h, v, 16, maskB, 8'hFF, 10'd1023);
        colorC = pixelVal(h, v, 18, maskC, 8'hFF, 10'd1023);
        if (rstLine >= 0 && v == rstLine && h == 10) rstN = 1'b0;
        if (rstLine >= 0 && v == rstLine + 1 && h == 10) rstN = 1'b1;
        @(posedge clk);
        edgeNo++;
        if (h == HS + 15 && v == VS + VA - 1) lastEdgeA = edgeNo;
        if (h == HS + 17 && v == VS + VA - 1) lastEdgeC = edgeNo;
        #1;
        if (validA) begin
          validCntA++;
          validEdgeA = edgeNo;
        end
        if (validB) validCntB++;
        if (validC) begin
          validCntC++;
          validEdgeC = edgeNo;
        end
      end
    end
  endtask

  initial begin
    rstN   = 1'b0;
    hCont  = '0;
    vCont  = '0;
    colorA = '0;
    colorB = '0;
    colorC = '0;
    maskA  = '0;
    maskB  = 32'h0000_F000;
    maskC  = 32'h0003_0000;
    rowsA  = 8'h0F;
    valA   = 10'd1023;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_dir", dirA, 4);
    checkOutput("reset_cand", candA, 4);
    checkOutput("reset_valid", validA, 0);
    checkOutput("reset_peak", peakA, 0);

    maskA = 32'h0000_0F00;
    applyStimulus(-1);
    checkOutput("f1_valid_count", validCntA, 1);
    checkOutput("f1_latency", validEdgeA - lastEdgeA, 6);
    checkOutput("f1_cand", candA, 2);
    checkOutput("f1_peak", peakA, 16);
    checkOutput("f1_dir_held", dirA, 4);
    checkOutput("b_cand", candB, 3);
    checkOutput("b_peak_sat", peakB, 7);
    checkOutput("c_valid_count", validCntC, 1);
    checkOutput("c_latency", validEdgeC - lastEdgeC, 6);
    checkOutput("c_cand_remainder", candC, 3);
    checkOutput("c_peak", peakC, 8);

    applyStimulus(-1);
    checkOutput("f2_valid_count", validCntA, 1);
    checkOutput("f2_dir", dirA, 2);
    checkOutput("b_dir", dirB, 3);
    checkOutput("c_dir", dirC, 3);

    maskA = 32'h0000_3030;
    applyStimulus(-1);
    checkOutput("tie_cand", candA, 1);
    checkOutput("tie_peak", peakA, 8);
    checkOutput("tie_dir_held", dirA, 2);

    maskA = 32'hFFFF_FFFF;
    rowsA = 8'hFF;
    valA  = 10'd200;
    applyStimulus(-1);
    checkOutput("thresh_eq_cand", candA, 4);
    checkOutput("thresh_eq_peak", peakA, 0);

    maskA = 32'h0000_0007;
    rowsA = 8'h01;
    valA  = 10'd201;
    applyStimulus(-1);
    checkOutput("min_eq_cand", candA, 0);
    checkOutput("min_eq_peak", peakA, 3);

    maskA = 32'h0000_0003;
    applyStimulus(-1);
    checkOutput("below_min_cand", candA, 4);
    checkOutput("below_min_peak", peakA, 0);
    checkOutput("below_min_dir", dirA, 2);
    applyStimulus(-1);
    checkOutput("none_debounced_dir", dirA, 4);

    maskA = 32'h0000_0F00;
    rowsA = 8'h0F;
    valA  = 10'd1023;
    applyStimulus(3);
    checkOutput("rst_frame_valid_count", validCntA, 0);
    checkOutput("rst_frame_cand", candA, 4);
    checkOutput("rst_frame_dir", dirA, 4);
    applyStimulus(-1);
    checkOutput("post_rst_valid_count", validCntA, 1);
    checkOutput("post_rst_cand", candA, 2);
    checkOutput("post_rst_peak", peakA, 16);
    checkOutput("post_rst_dir", dirA, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/motion_zone_tracker.md
Name: motion_zone_tracker

Overview:
- Parametrised successor to the column-binned direction detector in the camera/VGA path.
- Splits the active line into N_ZONES vertical strips. Per frame, counts pixels whose colour value exceeds a threshold in each strip, then picks the strip with the most pixels using a sequential argmax scan.
- A multi-frame debounce stabilises the result before driving oDirection to the game/control logic.
- Sits beside the VGA controller, sampling the same H/V counters and the processed colour stream.

Parameters:
- H_START, 216, first active horizontal count (sync + back porch)
- V_START, 27, first active vertical line
- H_ACT, 800, active pixels per line
- V_ACT, 600, active lines per frame
- N_ZONES, 7, number of strips (2..15); zone 0 is leftmost
- COLOR_THRESH, 200, pixel counts only if iColorVal > COLOR_THRESH
- MIN_PIXELS, 600, winning zone needs at least this many pixels, otherwise NONE
- HOLD_FRAMES, 3, consecutive identical frame candidates required before oDirection changes (≥1)
- CNT_W, 18, per-zone counter width
- Derived: ZW = clog2(N_ZONES+1); ZONE_W = H_ACT / N_ZONES; NONE = N_ZONES

Ports:
- iCLK  in  1  pixel clock
- iRST_N  in  1  asynchronous active-low reset
- iH_Cont  in  13  horizontal counter
- iV_Cont  in  13  vertical counter
- iColorVal  in  10  colour/motion magnitude of the current pixel
- oDirection  out  ZW  debounced winning zone, or NONE
- oValid  out  1  one-cycle pulse per completed frame evaluation
- oCandidate  out  ZW  raw winner of the last evaluated frame
- oPeakCount  out  CNT_W  pixel count of the last raw winner (0 if none)

Behaviour:
- Clocking and reset:
  - One clock: iCLK. Reset iRST_N is asynchronous, active-low.
  - Reset values: oDirection = NONE, oCandidate = NONE, oValid = 0, oPeakCount = 0. All zone counters 0, hold counter 0, last candidate NONE, state IDLE.
- State machine: IDLE -> ACCUM -> SCAN -> DECIDE -> IDLE.
- IDLE:
  - Waits for frame start: iV_Cont == V_START && iH_Cont == H_START.
  - On frame start: clear all counters, count that pixel, go to ACCUM.
  - Reset mid-frame therefore skips the partial frame; no oValid is produced for it.
- ACCUM:
  - A pixel is active when H in [H_START, H_START+H_ACT) and V in [V_START, V_START+V_ACT).
  - Zone index comes from a running column counter, not comparators. It is reset at H_START and advances the zone every ZONE_W pixels.
  - The last zone absorbs the remainder columns (H_ACT mod N_ZONES).
  - An active pixel with iColorVal > COLOR_THRESH increments its zone counter, saturating at 2^CNT_W−1.
  - The last active pixel (V = V_START+V_ACT−1, H = H_START+H_ACT−1) is counted, then the block moves to SCAN.
- SCAN:
  - One zone per cycle, indices 0..N_ZONES−1, N_ZONES cycles total.
  - Running max uses strict greater-than, so ties go to the lower index.
  - Counters are not modified during SCAN.
- DECIDE (1 cycle):
  - Raw candidate = max index if max ≥ MIN_PIXELS, else NONE.
  - Hold update: if candidate == last candidate, hold = min(hold+1, HOLD_FRAMES); else last = candidate and hold = 1.
  - If the new hold ≥ HOLD_FRAMES, oDirection <= candidate; otherwise oDirection is unchanged.
  - oCandidate and oPeakCount are updated. oPeakCount = max, or 0 when the candidate is NONE.
  - oValid is high for exactly this cycle's registered output, in the same edge as the other output updates.
- Latency: oValid rises N_ZONES+2 clock edges after the edge sampling the last active pixel.
- Frame start during SCAN/DECIDE:
  - Ignored; that frame is skipped.
  - Cannot occur with legal timing, because blanking exceeds N_ZONES+2 cycles.
- Abnormal counter timing: if V leaves the active region without hitting the last-pixel condition, ACCUM returns to IDLE with no oValid.

Decomposition:
- Package motion_zone_pkg holds:
  - state encoding (IDLE/ACCUM/SCAN/DECIDE)
  - clog2 function
  - default VGA 800x600 and 640x480 timing constants
- One sub-module, zone_argmax_scan: sequential max/index scanner over N_ZONES values with a start/done handshake, feeding DECIDE.

Test Plan:
Bench parameters: H_START=4, V_START=2, H_ACT=16, V_ACT=4, N_ZONES=4, MIN_PIXELS=3, HOLD_FRAMES=2, COLOR_THRESH=200.
1. Reset, then idle counters -> oDirection=4, oCandidate=4, oValid=0, oPeakCount=0.
2. Two frames lit (val 1023) only at columns 8–11, all rows:
   - Frame 1 -> oValid pulse exactly 6 edges after the last pixel; oCandidate=2, oPeakCount=16, oDirection=4.
   - Frame 2 -> oDirection=2.
3. Zones 1 and 3 each lit with 8 pixels -> oCandidate=1 (tie to lower index).
4. Threshold and minimum boundaries:
   - iColorVal=200 everywhere -> candidate 4.
   - 3 pixels of 201 in zone 0 -> candidate 0, peak 3.
   - 2 pixels -> candidate 4.
5. Reset asserted mid-ACCUM, released mid-frame -> no oValid that frame; next full frame reports normally.
6. Extra configurations:
   - CNT_W=3 with 16 lit pixels in zone 3 -> oPeakCount=7.
   - H_ACT=18: lit columns 16–17 -> candidate 3 (remainder columns go to the last zone).
